sort_out_pack: RTL and testbench

Output packing stage downstream of the sort top. It accepts the sparse, parallel, non-stallable sorted-output lanes (up to `SORT_PERF_OUTPORT_NUM` values per cycle, with a per-lane valid mask and a done pulse). It compacts them in lane order into a FIFO and presents a single-lane valid/ready stream to the consumer. The end-of-sort done pulse is carried through the FIFO as an in-order marker, so the consumer sees frame completion only after the last element has been accepted.

---
 rtl/sort_out_pack.sv | 116 +++++++++++
 tb/tb_sort_out_pack.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sort_out_pack.sv
// Compacts sparse parallel sorted-output lanes into a FIFO and drains them as a
// single valid/ready stream, carrying the end-of-frame done as an in-order marker.
module sort_out_pack #(
    parameter int SORT_FUC_MAX_NUM      = 1024,
    parameter int SORT_FUC_REPEAT_NUM   = 16,
    parameter int SORT_PERF_OUTPORT_NUM = 4,
    parameter int PACK_DEPTH            = 16,
    parameter int SORT_FUC_DATA_W       = $clog2(SORT_FUC_MAX_NUM),
    parameter int PACK_CNT_W            = $clog2(SORT_FUC_MAX_NUM*SORT_FUC_REPEAT_NUM+1)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [SORT_PERF_OUTPORT_NUM-1:0]           pack_in_vld_i,
    input  logic [SORT_PERF_OUTPORT_NUM*SORT_FUC_DATA_W-1:0] pack_in_data_i,
    input  logic                                       pack_in_done_vld_i,
    output logic                                       pack_out_vld_o,
    output logic [SORT_FUC_DATA_W-1:0]                 pack_out_data_o,
    input  logic                                       pack_out_rdy_i,
    output logic                                       pack_out_done_o,
    output logic [PACK_CNT_W-1:0]                      pack_out_cnt_o,
    output logic                                       pack_afull_o,
    output logic                                       pack_ovf_o
);
    localparam int P     = SORT_PERF_OUTPORT_NUM;
    localparam int W     = SORT_FUC_DATA_W;
    localparam int PTR_W = $clog2(PACK_DEPTH);
    localparam int OCC_W = $clog2(PACK_DEPTH+1);
    localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(PACK_DEPTH);
    localparam logic [OCC_W-1:0] AFULL_LIM = OCC_W'(P+1);

    // Entries beyond the free space are dropped; the caller flags overflow.
    function automatic logic [OCC_W-1:0] clip_to_free(input logic [OCC_W-1:0] req,
                                                      input logic [OCC_W-1:0] room);
        return (req > room) ? room : req;
    endfunction

    logic [W:0]            mem [PACK_DEPTH];
    logic [PTR_W-1:0]      rptr, wptr;
    logic [OCC_W-1:0]      occ;
    logic [PACK_CNT_W-1:0] frame_cnt;
    logic                  ovf;

    logic [OCC_W-1:0]      pre [P+1];
    logic [W:0]            slot [P+1];
    logic [OCC_W-1:0]      req_n, free_n, wr_n;
    logic [W:0]            head;
    logic                  head_live, head_done, pop;

    // Slot j takes the lane whose count of lower valid lanes equals j; the
    // marker lands right after the last valid lane.
    always_comb begin
        pre[0] = '0;
        for (int k = 0; k < P; k++) begin
            pre[k+1] = pre[k] + OCC_W'(pack_in_vld_i[k]);
        end
        for (int j = 0; j <= P; j++) begin
            slot[j] = '0;
            for (int k = 0; k < P; k++) begin
                if (pack_in_vld_i[k] && pre[k] == OCC_W'(j)) begin
                    slot[j] = {1'b0, pack_in_data_i[k*W +: W]};
                end
            end
            if (pack_in_done_vld_i && pre[P] == OCC_W'(j)) begin
                slot[j] = {1'b1, {W{1'b0}}};
            end
        end
        req_n = pre[P] + OCC_W'(pack_in_done_vld_i);
    end

    assign free_n = DEPTH_C - occ;
    assign wr_n   = clip_to_free(req_n, free_n);

    assign head      = mem[rptr];
    assign head_live = (occ != '0);
    assign head_done = head_live & head[W];

    assign pack_out_vld_o  = head_live & ~head[W];
    assign pack_out_data_o = head[W-1:0];
    assign pack_out_done_o = head_done;
    assign pack_out_cnt_o  = head_done ? frame_cnt : '0;
    assign pack_afull_o    = (free_n < AFULL_LIM);
    assign pack_ovf_o      = ovf;

    // A marker at the head always leaves; data leaves only when accepted.
    assign pop = head_done | (pack_out_vld_o & pack_out_rdy_i);

    always_ff @(posedge clk) begin
        for (int j = 0; j <= P; j++) begin
            if (OCC_W'(j) < wr_n) begin
                mem[wptr + PTR_W'(j)] <= slot[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr      <= '0;
            wptr      <= '0;
            occ       <= '0;
            frame_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            rptr <= rptr + PTR_W'(pop);
            wptr <= wptr + wr_n[PTR_W-1:0];
            occ  <= occ + wr_n - OCC_W'(pop);
            if (head_done) begin
                frame_cnt <= '0;
            end else if (pack_out_vld_o && pack_out_rdy_i) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (req_n > free_n) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sort_out_pack.sv
// Directed bench for sort_out_pack: a queue-based model is compared every cycle,
// and hand-computed literal expectations pin key points of each scenario.
module tb_sort_out_pack;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  in_vld = '0;
    logic [39:0] in_data = '0;
    logic        in_done = 1'b0;
    logic        rdy = 1'b0;
    logic        out_vld, out_done, afull, ovf;
    logic [9:0]  out_data;
    logic [14:0] out_cnt;

    int vec = 0;
    int miscmp = 0;

    // Model state: entries are data values, 1024 encodes the done marker.
    int q[$];
    int m_cnt = 0;
    bit m_ovf = 1'b0;

    sort_out_pack dut (
        .clk(clk), .rst(rst),
        .pack_in_vld_i(in_vld), .pack_in_data_i(in_data), .pack_in_done_vld_i(in_done),
        .pack_out_vld_o(out_vld), .pack_out_data_o(out_data), .pack_out_rdy_i(rdy),
        .pack_out_done_o(out_done), .pack_out_cnt_o(out_cnt),
        .pack_afull_o(afull), .pack_ovf_o(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] pk(input int d0, input int d1, input int d2, input int d3);
        return {10'(d3), 10'(d2), 10'(d1), 10'(d0)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            miscmp++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic cyc(input logic [3:0] v, input logic [39:0] d, input logic dn, input logic r);
        in_vld = v; in_data = d; in_done = dn; rdy = r;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: pop decided from the head, space judged before the pop.
    initial begin
        int free_m;
        int req[$];
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete(); m_cnt = 0; m_ovf = 1'b0;
            end else begin
                free_m = 16 - q.size();
                if (q.size() > 0) begin
                    if (q[0] == 1024) begin
                        void'(q.pop_front()); m_cnt = 0;
                    end else if (rdy) begin
                        void'(q.pop_front()); m_cnt++;
                    end
                end
                req.delete();
                for (int k = 0; k < 4; k++)
                    if (in_vld[k]) req.push_back(int'(in_data[k*10 +: 10]));
                if (in_done) req.push_back(1024);
                for (int i = 0; i < req.size(); i++) begin
                    if (i < free_m) q.push_back(req[i]);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    initial begin
        int hd;
        bit e_vld, e_done, e_afull, ok;
        forever begin
            @(negedge clk);
            if (rst) begin
                hd      = (q.size() > 0) ? q[0] : 0;
                e_vld   = (q.size() > 0) && (hd != 1024);
                e_done  = (q.size() > 0) && (hd == 1024);
                e_afull = (16 - q.size()) < 5;
                ok = (out_vld == e_vld) && (out_done == e_done) && (afull == e_afull)
                     && (ovf == m_ovf) && (!e_vld || int'(out_data) == hd)
                     && (!e_done || int'(out_cnt) == m_cnt);
                vec++;
                if (!ok) begin
                    miscmp++;
                    $display("FAIL cycle_model t=%0t: got vld=%0b done=%0b data=%0d cnt=%0d afull=%0b ovf=%0b, expected vld=%0b done=%0b data=%0d cnt=%0d afull=%0b ovf=%0b",
                             $time, out_vld, out_done, out_data, out_cnt, afull, ovf,
                             e_vld, e_done, hd, m_cnt, e_afull, m_ovf);
                end
            end
        end
    end

    initial begin
        // Reset state
        #23;
        chk("rst_vld", out_vld, 0);
        chk("rst_done", out_done, 0);
        chk("rst_cnt", out_cnt, 0);
        chk("rst_afull", afull, 0);
        chk("rst_ovf", ovf, 0);
        #4 rst = 1'b1;
        @(posedge clk); #1;

        // Single element on lane 2
        cyc(4'b0100, pk(0, 0, 'h155, 0), 0, 1);
        chk("single_vld", out_vld, 1);
        chk("single_data", out_data, 'h155);
        cyc(4'b0000, '0, 0, 1);
        chk("single_empty", out_vld, 0);

        // Sparse compaction 4'b1011
        cyc(4'b1011, pk(5, 9, 7, 3), 0, 1);
        chk("sparse_0", out_data, 5);
        cyc(4'b0000, '0, 0, 1);
        chk("sparse_1", out_data, 9);
        cyc(4'b0000, '0, 0, 1);
        chk("sparse_2", out_data, 3);
        cyc(4'b0000, '0, 0, 1);
        chk("sparse_empty", out_vld, 0);

        // Lone done closes the frame of 4 elements popped so far
        cyc(4'b0000, '0, 1, 1);
        chk("flush_done", out_done, 1);
        chk("flush_cnt", out_cnt, 4);
        cyc(4'b0000, '0, 0, 1);
        chk("flush_done_clr", out_done, 0);

        // Done ordered after same-cycle data
        cyc(4'b0011, pk(1, 2, 0, 0), 1, 1);
        chk("ord_d1", out_data, 1);
        cyc(4'b0000, '0, 0, 1);
        chk("ord_d2", out_data, 2);
        cyc(4'b0000, '0, 0, 1);
        chk("ord_done", out_done, 1);
        chk("ord_vld_low", out_vld, 0);
        chk("ord_cnt", out_cnt, 2);
        cyc(4'b0000, '0, 1, 1);
        chk("zero_frame_done", out_done, 1);
        chk("zero_frame_cnt", out_cnt, 0);
        cyc(4'b0000, '0, 0, 1);

        // Backpressure: 12 queued, then drain
        for (int c = 0; c < 3; c++) cyc(4'b1111, pk(16+4*c, 17+4*c, 18+4*c, 19+4*c), 0, 0);
        chk("bp_afull", afull, 1);
        cyc(4'b0000, '0, 0, 0);
        chk("bp_hold", out_data, 16);
        for (int i = 0; i < 12; i++) begin
            chk("bp_vld", out_vld, 1);
            chk("bp_data", out_data, 16 + i);
            cyc(4'b0000, '0, 0, 1);
        end
        chk("bp_empty", out_vld, 0);
        chk("bp_afull_clr", afull, 0);
        cyc(4'b0000, '0, 1, 1);
        chk("bp_cnt", out_cnt, 12);
        cyc(4'b0000, '0, 0, 1);

        // Overflow: fill 16, then a dropped full cycle plus done
        for (int c = 0; c < 4; c++) cyc(4'b1111, pk(100+4*c, 101+4*c, 102+4*c, 103+4*c), 0, 0);
        chk("ovf_afull", afull, 1);
        chk("ovf_not_yet", ovf, 0);
        cyc(4'b1111, pk(200, 201, 202, 203), 1, 0);
        chk("ovf_set", ovf, 1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_data", out_data, 100 + i);
            cyc(4'b0000, '0, 0, 1);
        end
        chk("ovf_empty", out_vld, 0);
        chk("ovf_no_done", out_done, 0);
        chk("ovf_sticky", ovf, 1);
        cyc(4'b0000, '0, 1, 1);
        chk("ovf_cnt", out_cnt, 16);
        cyc(4'b0000, '0, 0, 1);

        // Asynchronous reset with 6 entries queued
        cyc(4'b1111, pk(300, 301, 302, 303), 0, 0);
        cyc(4'b0011, pk(304, 305, 0, 0), 0, 0);
        chk("pre_rst_data", out_data, 300);
        in_vld = '0; in_done = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_vld", out_vld, 0);
        chk("arst_done", out_done, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_afull", afull, 0);
        #2 rst = 1'b1;
        cyc(4'b0001, pk(42, 0, 0, 0), 0, 1);
        chk("post_rst_vld", out_vld, 1);
        chk("post_rst_data", out_data, 42);
        cyc(4'b0000, '0, 0, 1);
        chk("post_rst_empty", out_vld, 0);
        cyc(4'b0000, '0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
